// File: rtl/seq_adder.sv
// seq_adder: multi-cycle adder/subtractor that processes CHUNK bits per clock.
// Operands are captured in IDLE and summed one chunk per cycle in RUN.
// The result and flags are presented in DONE until the consumer takes them.
module seq_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int K    = WIDTH / CHUNK;
    localparam int IDXW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(K - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;      // already inverted for subtract
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;  // carry chained between chunks
    logic             cout_r;
    logic             ovf_r;

    int               base;
    logic [CHUNK-1:0] a_ch;
    logic [CHUNK-1:0] b_ch;
    logic [CHUNK-1:0] s_ch;
    logic             c_out_ch;
    logic             c_msb;

    // Chunk adder for the current index; also recovers the carry into the
    // chunk's top bit, which on the last chunk is the carry into the MSB.
    always_comb begin
        base = int'(idx) * CHUNK;
        a_ch = a_r[base +: CHUNK];
        b_ch = b_r[base +: CHUNK];
        {c_out_ch, s_ch} = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_r};
        c_msb = s_ch[CHUNK-1] ^ a_ch[CHUNK-1] ^ b_ch[CHUNK-1];
    end

    // Control FSM: accept in IDLE, step the chunk index in RUN, hold in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (idx == LAST) state <= DONE;
                    else             idx   <= idx + 1'b1;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: operand capture, per-chunk sum write-back and final flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                // Subtract is a + ~b + ~borrow_in.
                a_r     <= a;
                b_r     <= sub ? ~b : b;
                carry_r <= sub ? ~carry_in : carry_in;
            end else if (state == RUN) begin
                sum_r[base +: CHUNK] <= s_ch;
                carry_r              <= c_out_ch;
                if (idx == LAST) begin
                    cout_r <= c_out_ch;
                    ovf_r  <= c_msb ^ c_out_ch;
                end
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;
    // Only asserted on a complete result so reset and partial sums never flag zero.
    assign zero      = (state == DONE) && (sum_r == '0);

endmodule

// File: tb/tb_seq_adder.sv
// Bench for seq_adder: directed cases on a 16/4 instance plus randomized
// sweeps on 16/16, 16/1 and 32/8 instances against an arithmetic model.
module tb_seq_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int sw_done_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_n_d = 1'b1;
    logic rst_s   = 1'b1;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic void model(input int w, input longint av_in, input longint bv_in,
                                  input bit ci, input bit sb, output longint s,
                                  output bit co, output bit ov, output bit z);
        longint mask, half, av, bv, cl, full, sa, sbv, tru;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        av   = av_in & mask;
        bv   = bv_in & mask;
        cl   = ci ? 1 : 0;
        if (!sb) begin
            full = av + bv + cl;
            co   = (full > mask);
        end else begin
            full = av - bv - cl;
            co   = (av >= bv + cl);
        end
        s   = full & mask;
        sa  = (av ^ half) - half;
        sbv = (bv ^ half) - half;
        tru = sb ? (sa - sbv - cl) : (sa + sbv + cl);
        ov  = (tru >= half) || (tru < -half);
        z   = (s == 0);
    endfunction

    // ---------------- directed instance, WIDTH=16 CHUNK=4 ----------------
    logic        d_in_valid = 1'b0, d_in_ready, d_cin = 1'b0, d_sub = 1'b0;
    logic        d_out_valid, d_out_ready = 1'b0, d_cout, d_ovf, d_zero;
    logic [15:0] d_a = '0, d_b = '0, d_sum;

    seq_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .rst_n(rst_n_d), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .a(d_a), .b(d_b), .carry_in(d_cin), .sub(d_sub), .out_valid(d_out_valid),
        .out_ready(d_out_ready), .sum(d_sum), .cout(d_cout), .ovf(d_ovf), .zero(d_zero)
    );

    task automatic d_op(input logic [15:0] av, input logic [15:0] bv, input bit ci,
                        input bit sb, input int stall, output logic [15:0] rs,
                        output bit rco, output bit rov, output bit rz);
        int n = 0;
        @(negedge clk);
        while (d_in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("d_accept_wait", longint'(n < 50), 1);
        d_a = av; d_b = bv; d_cin = ci; d_sub = sb; d_in_valid = 1'b1;
        @(posedge clk); #1 d_in_valid = 1'b0;
        n = 0;
        while (d_out_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        check("d_latency", n, 4);
        rs = d_sum; rco = d_cout; rov = d_ovf; rz = d_zero;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("d_stall_sum", d_sum, rs);
            check("d_stall_flags", {d_cout, d_ovf, d_zero}, {rco, rov, rz});
            check("d_stall_hs", {d_out_valid, d_in_ready}, 2'b10);
        end
        d_out_ready = 1'b1;
        @(posedge clk); #1 d_out_ready = 1'b0;
        check("d_after_hs", {d_out_valid, d_in_ready}, 2'b01);
    endtask

    task automatic d_case(input string nm, input logic [15:0] av, input logic [15:0] bv,
                          input bit ci, input bit sb, input int stall,
                          input logic [15:0] es, input bit eco, input bit eov, input bit ez);
        logic [15:0] rs;
        bit          rco, rov, rz, mco, mov, mz;
        longint      ms;
        model(16, longint'(av), longint'(bv), ci, sb, ms, mco, mov, mz);
        check({nm, "_model_sum"}, ms, es);
        check({nm, "_model_flags"}, {mco, mov, mz}, {eco, eov, ez});
        d_op(av, bv, ci, sb, stall, rs, rco, rov, rz);
        check({nm, "_sum"}, rs, es);
        check({nm, "_flags"}, {rco, rov, rz}, {eco, eov, ez});
    endtask

    // ---------------- randomized sweep instances ----------------
    for (genvar g = 0; g < 3; g++) begin : sw
        localparam int W = (g == 2) ? 32 : 16;
        localparam int C = (g == 0) ? 16 : ((g == 1) ? 1 : 8);
        localparam int K = W / C;

        logic         iv = 1'b0, ir, ci = 1'b0, sb = 1'b0, ovld, ordy = 1'b0, co, ov, z;
        logic [W-1:0] av = '0, bv = '0, s;
        logic [W-1:0] q_s[$];
        bit           q_co[$], q_ov[$], q_z[$];
        int           t_acc = 0;
        bit           seen = 1'b0;

        seq_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clk(clk), .rst_n(rst_s), .in_valid(iv), .in_ready(ir),
            .a(av), .b(bv), .carry_in(ci), .sub(sb), .out_valid(ovld),
            .out_ready(ordy), .sum(s), .cout(co), .ovf(ov), .zero(z)
        );

        // Driver: random operands with a few forced corner patterns.
        initial begin
            longint es;
            bit     eco, eov, ez;
            int     w;
            @(posedge rst_s);
            for (int n = 0; n < 1000; n++) begin
                w = 0;
                @(negedge clk);
                while (ir !== 1'b1 && w < 100) begin @(negedge clk); w++; end
                if (w == 100) begin check($sformatf("sw%0d_accept_wait", g), w, 0); break; end
                av = W'($urandom);
                bv = W'($urandom);
                ci = 1'($urandom);
                sb = 1'($urandom);
                if (n % 16 == 0) av = '1;
                if (n % 16 == 1) bv = av;
                if (n % 16 == 2) av = {1'b0, {(W-1){1'b1}}};
                if (n % 16 == 3) bv = {1'b1, {(W-1){1'b0}}};
                model(W, longint'(av), longint'(bv), ci, sb, es, eco, eov, ez);
                q_s.push_back(W'(es)); q_co.push_back(eco);
                q_ov.push_back(eov);   q_z.push_back(ez);
                iv = 1'b1;
                @(posedge clk); #1 iv = 1'b0;
                t_acc = cyc;
            end
            w = 0;
            while (q_s.size() != 0 && w < 200) begin @(negedge clk); w++; end
            check($sformatf("sw%0d_drain", g), q_s.size(), 0);
            sw_done_cnt++;
        end

        // Compare process: every cycle a result is presented, with random backpressure.
        always @(negedge clk) begin
            if (rst_s === 1'b1 && ovld === 1'b1) begin
                if (q_s.size() == 0) begin
                    check($sformatf("sw%0d_spurious_valid", g), 1, 0);
                end else begin
                    if (!seen) begin
                        check($sformatf("sw%0d_latency", g), cyc - t_acc, K);
                        seen = 1'b1;
                    end
                    check($sformatf("sw%0d_sum", g), s, q_s[0]);
                    check($sformatf("sw%0d_flags", g), {co, ov, z}, {q_co[0], q_ov[0], q_z[0]});
                    check($sformatf("sw%0d_in_ready", g), ir, 0);
                end
                ordy = ($urandom_range(0, 3) != 0);
                if (ordy && q_s.size() != 0) begin
                    void'(q_s.pop_front()); void'(q_co.pop_front());
                    void'(q_ov.pop_front()); void'(q_z.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        bit any_valid;
        int n;
        rst_n_d = 1'b0;
        rst_s   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sum", d_sum, 0);
        check("rst_flags", {d_cout, d_ovf, d_zero, d_out_valid}, 0);
        rst_n_d = 1'b1;
        rst_s   = 1'b1;
        @(negedge clk);
        check("rst_in_ready", d_in_ready, 1);

        d_case("basic_add", 16'h1234, 16'h0FCD, 1'b0, 1'b0, 0, 16'h2201, 1'b0, 1'b0, 1'b0);
        d_case("wrap_add",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 16'h0000, 1'b1, 1'b0, 1'b1);
        d_case("ovf_add",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 16'h8000, 1'b0, 1'b1, 1'b0);
        d_case("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 5, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        d_case("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        d_case("sub_bin",   16'h0010, 16'h0001, 1'b1, 1'b1, 2, 16'h000E, 1'b1, 1'b0, 1'b0);
        d_case("add_cin",   16'h00FF, 16'h0000, 1'b1, 1'b0, 0, 16'h0100, 1'b0, 1'b0, 1'b0);

        // Abort an operation at chunk 2 with an unclocked reset.
        @(negedge clk);
        d_a = 16'h1234; d_b = 16'h1111; d_cin = 1'b0; d_sub = 1'b0; d_in_valid = 1'b1;
        @(posedge clk); #1 d_in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n_d = 1'b0;
        #1;
        check("midrst_sum", d_sum, 0);
        check("midrst_flags", {d_cout, d_ovf, d_zero, d_out_valid}, 0);
        any_valid = 1'b0;
        repeat (2) begin @(negedge clk); any_valid |= d_out_valid; end
        rst_n_d = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready", d_in_ready, 1);
        repeat (6) begin @(negedge clk); any_valid |= d_out_valid; end
        check("midrst_no_valid", any_valid, 0);
        d_case("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 0, 16'h0002, 1'b0, 1'b0, 1'b0);

        n = 0;
        while (sw_done_cnt < 3 && n < 60000) begin @(negedge clk); n++; end
        check("sweep_done", sw_done_cnt, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
